// File: rtl/alu_exec_ctrl_pkg.sv
// Shared types and constants for the ALU decode/execute stage.
// Control codes keep the legacy 3-bit values for the original ALU ops.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_MD   = 4'b1111
  } alu_ctrl_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Which operands of an M op are interpreted as two's complement.
  function automatic logic md_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_md_iter.sv
// Iterative multiply (shift/add) and restoring divide on operand magnitudes.
// Runs XLEN steps after start; result is valid combinationally while last is high.
module md_iter
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            last
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]     cnt;
  logic              active;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   hi, lo, bop;
  logic              neg, neg_r, bzero;

  logic              sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, shifted, diff;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    sa    = md_a_signed(op) & a[XLEN-1];
    sb    = md_b_signed(op) & b[XLEN-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // One iteration of either engine; hi/lo double as product or remainder/quotient.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, bop} : {(XLEN+1){1'b0}});
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, bop};
    if (op_q[2]) begin
      hi_n = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end

  // Sign fix-up applied to the output of the final iteration.
  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg ? -prod : prod;
    quo    = bzero ? {XLEN{1'b1}} : (neg ? -lo_n : lo_n);
    rem    = neg_r ? -hi_n : hi_n;
    case (op_q)
      F3_MUL:                       result = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              result = quo;
      default:                      result = rem;
    endcase
  end

  assign last = active && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      hi     <= '0;
      lo     <= '0;
      bop    <= '0;
      neg    <= 1'b0;
      neg_r  <= 1'b0;
      bzero  <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      op_q   <= op;
      hi     <= '0;
      lo     <= op[2] ? mag_a : mag_b;
      bop    <= op[2] ? mag_b : mag_a;
      neg    <= sa ^ sb;
      neg_r  <= sa;
      bzero  <= (b == '0);
    end else if (active) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + CW'(1);
      if (last) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Registered ALU decode/execute stage: single-cycle ALU ops plus iterative RV M ops.
// ready_o stalls the pipeline for the XLEN cycles an M op occupies the engine.
module alu_exec_ctrl
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            opcode_5,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [3:0]      alu_ctrl_o,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            valid_o,
  output logic            busy_o
);

  localparam int SHW = $clog2(XLEN);

  function automatic alu_ctrl_t decode_ctrl(input logic [1:0] aluop, input logic [2:0] f3,
                                            input logic f75, input logic f70, input logic op5);
    alu_ctrl_t c;
    c = ALU_ADD;
    case (aluop)
      ALUOP_SUB: c = ALU_SUB;
      ALUOP_FUNCT: begin
        if (op5 & f70) begin
          c = ALU_MD;
        end else begin
          case (f3)
            3'b000:  c = (op5 & f75) ? ALU_SUB : ALU_ADD;
            3'b001:  c = ALU_SLL;
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            3'b100:  c = ALU_XOR;
            3'b101:  c = f75 ? ALU_SRA : ALU_SRL;
            3'b110:  c = ALU_OR;
            default: c = ALU_AND;
          endcase
        end
      end
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

  function automatic logic [XLEN-1:0] alu_exec(input alu_ctrl_t c, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    logic [XLEN-1:0] r;
    sh = b[SHW-1:0];
    case (c)
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SRA:  r = $signed(a) >>> sh;
      ALU_SRL:  r = a >> sh;
      ALU_SLL:  r = a << sh;
      default:  r = a + b;
    endcase
    return r;
  endfunction

  state_t          state, state_d;
  alu_ctrl_t       ctrl;
  logic            accept, is_md, md_last;
  logic [XLEN-1:0] alu_res, md_res;

  assign ctrl       = decode_ctrl(ALUOp, funct3, funct7_5, funct7_0, opcode_5);
  assign alu_ctrl_o = ctrl;
  assign is_md      = (ctrl == ALU_MD);
  assign alu_res    = alu_exec(ctrl, a_i, b_i);

  assign ready_o = (state != RUN);
  assign valid_o = (state == DONE);
  assign busy_o  = (state == RUN);
  assign accept  = valid_i && ready_o;

  md_iter #(.XLEN(XLEN)) u_md_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && is_md),
    .op     (funct3),
    .a      (a_i),
    .b      (b_i),
    .result (md_res),
    .last   (md_last)
  );

  always_comb begin
    state_d = state;
    case (state)
      RUN: begin
        if (md_last) state_d = DONE;
      end
      default: begin
        if (accept) state_d = is_md ? RUN : DONE;
        else        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      result_o <= '0;
      zero_o   <= 1'b1;
    end else begin
      state <= state_d;
      if (accept && !is_md) begin
        result_o <= alu_res;
        zero_o   <= (alu_res == '0);
      end else if ((state == RUN) && md_last) begin
        result_o <= md_res;
        zero_o   <= (md_res == '0);
      end
    end
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Registered ALU decode-and-execute stage for the RISC-V core, parametrised in datapath width. It extends the base ALU control decode with XOR/SRL/SLL/SLTU and the RV M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). Single-cycle ALU ops run at one per cycle. M ops run on an iterative shift/add–subtract engine behind a valid/ready handshake. It sits between the main decoder/register read and writeback, and stalls the pipeline through `ready_o`.

## Interface
- `XLEN`, default 32: operand/result width. Must be a power of 2 and ≥ 8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  operation request.
- `ready_o`  out  1  request can be accepted this cycle.
- `ALUOp`  in  2  00 add, 01 sub, 10 decode from funct fields, 11 reserved (treated as add).
- `funct3`  in  3  instruction funct3.
- `funct7_5`  in  1  instruction bit 30.
- `funct7_0`  in  1  instruction bit 25 (M-extension select).
- `opcode_5`  in  1  opcode bit 5 (1 = R-type, 0 = I-type).
- `a_i`, `b_i`  in  XLEN  operands.
- `alu_ctrl_o`  out  4  combinational decoded control for the current inputs.
- `result_o`  out  XLEN  registered result.
- `zero_o`  out  1  registered flag, `result_o == 0`.
- `valid_o`  out  1  `result_o` is valid this cycle; one-cycle pulse per accepted op.
- `busy_o`  out  1  M op in progress.

## Operation
- Accept occurs on any rising edge where `valid_i && ready_o`.
- `ready_o` = state is IDLE or DONE.
- Control codes, with the legacy 3-bit values preserved:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sra, 0111 srl, 1000 sll, 1001 sltu, 1111 MD.
- Decode when ALUOp=10:
  - MD when `opcode_5 & funct7_0`; funct3 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (000..111).
  - Otherwise funct3 000 → sub if `opcode_5 & funct7_5`, else add; 001 sll; 010 slt; 011 sltu; 100 xor; 101 → sra if `funct7_5`, else srl; 110 or; 111 and.
- Undefined combinations decode to add; no X is ever produced.
- Shift amount is `b_i[log2(XLEN)-1:0]`. slt/sltu return 0 or 1, zero-extended.
- States:
  - IDLE → DONE on accept of a non-MD op.
  - IDLE → RUN on accept of an MD op.
  - RUN → DONE after XLEN iterations.
  - DONE → IDLE with no accept; → DONE on a non-MD accept; → RUN on an MD accept.
- `valid_o` = state is DONE. `busy_o` = state is RUN.
- MD engine:
  - Operands are latched at accept. Signed ops work on magnitudes with a sign fix-up on the final iteration.
  - MUL returns the low XLEN bits of the 2·XLEN-bit product; MULH/MULHSU/MULHU return the high XLEN bits.
- Division corner cases (fixed latency, no early exit):
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder 0.
- `result_o` and `zero_o` hold their value until the next result is written.
- `valid_i` is ignored while RUN.

## Timing
- Reset (any state, including mid-RUN) → next cycle: IDLE, `result_o`=0, `zero_o`=1, `valid_o`=0, `busy_o`=0, `ready_o`=1. The in-flight op is dropped.
- Non-MD latency is 1: `valid_o` is high in the cycle after the accept edge. Back-to-back accepts give one result per cycle.
- MD latency is XLEN+1 edges: the accept edge loads operands, iterations run on the next XLEN edges, and the last iteration writes `result_o`. `valid_o` is high in the cycle after that edge.
- `ready_o` is low for exactly XLEN cycles after an MD accept.
- There is no output backpressure: the consumer must capture `result_o` while `valid_o` is high.
- `alu_ctrl_o` is purely combinational from the decode inputs, with no registered dependency.

## Structure
- Package `alu_exec_pkg`:
  - 4-bit `alu_ctrl_t` enum holding the codes above.
  - `ALUOp` constants.
  - Funct3 constants for M ops.
  - State enum {IDLE, RUN, DONE}.
- Sub-module `md_iter`:
  - Iterative multiply/divide engine: `start`, op select, operands in; result and `last` out.
  - Owns the iteration counter of width log2(XLEN)+1.
- Decode logic is a combinational function in the top level.

## Test plan
- Add/sub decode, XLEN=32:
  - a=5, b=7, ALUOp=10, funct3=000, `opcode_5`=1, `funct7_5`=1 → `result_o`=0xFFFFFFFE, `valid_o` 1 cycle after accept.
  - Same with `opcode_5`=0 → 12.
- Shifts: a=0x80000000, b=0x24 → sra 0xF8000000, srl 0x08000000, sll 0x00000000 with `zero_o`=1.
- Multiply: a=0xFFFFFFFF, b=2:
  - MUL → 0xFFFFFFFE; MULH → 0xFFFFFFFF; MULHU → 0x00000001; MULHSU → 0xFFFFFFFF.
  - `valid_o` exactly 33 edges after accept; `ready_o`=0 for the 32 cycles in between.
- Divide:
  - DIVU 100/7 → 14, REMU → 2.
  - DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF.
  - DIV 7/0 → 0xFFFFFFFF, REM 7/0 → 7.
  - DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Throughput and ignore:
  - Three back-to-back add/and/xor accepts → three consecutive `valid_o` cycles, in order.
  - `valid_i` held high during RUN → no extra accept; the next op is accepted in the DONE cycle.
- Reset mid-DIV at iteration 10 → next cycle `ready_o`=1, `valid_o`=0, `result_o`=0, and no late `valid_o` pulse over the following 40 cycles.
